// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor index type, default floor count and
// motor direction encodings used by the request unit and the controller.
package elevator_pkg;

    localparam int DEF_NUM_FLOORS = 3;
    localparam int DEF_FLOOR_W    = 2;

    typedef logic [DEF_FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        STOP = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } motor_dir_t;

endpackage

// File: rtl/elevator_request_unit_btn_debounce.sv
// One call button: two-flop synchroniser, saturating debounce counter and a
// registered one-cycle accept pulse on each rising edge of the debounced level.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic accept
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             accept_q, accept_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        cnt_d   = '0;
        if (sync2_q) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
        // Level rises on the edge the count first reaches the threshold.
        level_d  = sync2_q & (level_q | (cnt_d == CNT_MAX));
        accept_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            accept_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            accept_q <= accept_d;
        end
    end

    assign accept = accept_q;

endmodule

// File: rtl/elevator_request_unit.sv
// Call-button front end: debounced sticky request vector plus door dwell timer.
// Define DOOR_HOLD_EN to add the door_hold input that suspends the dwell.
module elevator_request_unit
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = DEF_NUM_FLOORS,
    parameter int FLOOR_W         = DEF_FLOOR_W,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DOOR_CYCLES     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door,
`ifdef DOOR_HOLD_EN
    input  logic                  door_hold,
`endif
    output logic [NUM_FLOORS-1:0] req_floor,
    output logic                  req_pending,
    output logic                  timer_expired
);

    localparam int DW = $clog2(DOOR_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DOOR_CYCLES - 1);

    logic [NUM_FLOORS-1:0] accept_vec;
    logic [NUM_FLOORS-1:0] clear_vec;
    logic [NUM_FLOORS-1:0] req_floor_q, req_floor_d;
    logic                  req_pending_q, req_pending_d;
    logic [DW-1:0]         dwell_q, dwell_d;
    logic                  timer_expired_q, timer_expired_d;
    logic                  hold_w;

`ifdef DOOR_HOLD_EN
    assign hold_w = door_hold;
`else
    assign hold_w = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .reset  (reset),
                .btn_raw(btn[gi]),
                .accept (accept_vec[gi])
            );
            // Out-of-range floor codes never match, so they clear nothing.
            assign clear_vec[gi] = door && (current_floor == FLOOR_W'(gi));
        end
    endgenerate

    always_comb begin
        // A call at the floor being served is dropped: clear beats accept.
        req_floor_d   = (req_floor_q | accept_vec) & ~clear_vec;
        req_pending_d = |req_floor_d;

        dwell_d         = '0;
        timer_expired_d = 1'b0;
        if (door && !hold_w) begin
            if (dwell_q == DWELL_LAST) begin
                timer_expired_d = 1'b1;
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_floor_q     <= '0;
            req_pending_q   <= 1'b0;
            dwell_q         <= '0;
            timer_expired_q <= 1'b0;
        end else begin
            req_floor_q     <= req_floor_d;
            req_pending_q   <= req_pending_d;
            dwell_q         <= dwell_d;
            timer_expired_q <= timer_expired_d;
        end
    end

    assign req_floor     = req_floor_q;
    assign req_pending   = req_pending_q;
    assign timer_expired = timer_expired_q;

endmodule

// File: tb/tb_elevator_request_unit.sv
// Self-checking bench for elevator_request_unit: directed scenarios followed by
// random traffic, all compared each cycle against a sample-history reference model.
module tb_elevator_request_unit;

    localparam int NF   = 3;
    localparam int FW   = 2;
    localparam int DB   = 4;
    localparam int DC   = 8;
    localparam int HMAX = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] btn;
    logic [FW-1:0] current_floor;
    logic          door;
    logic          hold_v;
    logic [NF-1:0] req_floor;
    logic          req_pending;
    logic          timer_expired;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: raw button samples per edge since reset.
    bit            hist [NF][HMAX];
    int            e;
    logic [NF-1:0] m_req;
    logic          m_pend;
    logic          m_exp;
    int            door_run;

    elevator_request_unit #(
        .NUM_FLOORS     (NF),
        .FLOOR_W        (FW),
        .DEBOUNCE_CYCLES(DB),
        .DOOR_CYCLES    (DC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn          (btn),
        .current_floor(current_floor),
        .door         (door),
`ifdef DOOR_HOLD_EN
        .door_hold    (hold_v),
`endif
        .req_floor    (req_floor),
        .req_pending  (req_pending),
        .timer_expired(timer_expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int run_len(input int f, input int last);
        int n = 0;
        for (int k = last; k >= 0; k--) begin
            if (!hist[f][k]) break;
            n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < NF; f++)
            for (int k = 0; k < HMAX; k++) hist[f][k] = 1'b0;
        e        = 0;
        m_req    = '0;
        m_pend   = 1'b0;
        m_exp    = 1'b0;
        door_run = 0;
    endtask

    // One clock: update the model from the sampled inputs, check, return at negedge.
    task automatic cycle();
        bit acc;
        bit clr;
        @(posedge clk);
        for (int f = 0; f < NF; f++) begin
            if (e < HMAX) hist[f][e] = btn[f];
            // Accept lands when a high run of exactly DB samples ended 3 edges ago.
            acc = (e >= 3) && (run_len(f, e - 3) == DB);
            clr = door && (int'(current_floor) == f);
            if (clr)      m_req[f] = 1'b0;
            else if (acc) m_req[f] = 1'b1;
        end
        m_pend = |m_req;
        if (door && !hold_v) begin
            door_run++;
            m_exp = ((door_run % DC) == 0);
        end else begin
            door_run = 0;
            m_exp    = 1'b0;
        end
        e++;
        #1;
        check("req_floor", 32'(req_floor), 32'(m_req));
        check("req_pending", 32'(req_pending), 32'(m_pend));
        check("timer_expired", 32'(timer_expired), 32'(m_exp));
        @(negedge clk);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int first_seen;
        int pulses;
        logic [31:0] mask;

        reset = 1'b1; btn = '0; current_floor = '0; door = 1'b0; hold_v = 1'b0;
        model_reset();
        #2;
        check("reset_req_floor", 32'(req_floor), 32'd0);
        check("reset_req_pending", 32'(req_pending), 32'd0);
        check("reset_timer_expired", 32'(timer_expired), 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Idle after reset.
        cycles(20);
        check("idle_req_floor", 32'(req_floor), 32'd0);

        // Clean press on floor 2: request appears on the 7th edge of the press.
        btn[2] = 1'b1;
        first_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (first_seen == 0 && req_floor[2]) first_seen = i;
        end
        check("press_latency", 32'(first_seen), 32'd7);
        btn[2] = 1'b0;
        cycles(10);
        check("press_hold", 32'(req_floor), 32'b100);

        // Three-cycle glitch is rejected; a four-cycle press is accepted.
        btn[1] = 1'b1; cycles(3); btn[1] = 1'b0; cycles(10);
        check("glitch_reject", 32'(req_floor), 32'b100);
        btn[0] = 1'b1; cycles(4); btn[0] = 1'b0; cycles(10);
        check("boundary_accept", 32'(req_floor), 32'b101);

        // Service clear at floor 0, then a new call there while the door is open.
        current_floor = 2'd0; door = 1'b1;
        cycle();
        check("service_clear", 32'(req_floor), 32'b100);
        btn[0] = 1'b1; cycles(10); btn[0] = 1'b0; cycles(2);
        check("open_floor_call_dropped", 32'(req_floor), 32'b100);

        // Out-of-range floor code clears nothing.
        door = 1'b0; cycles(2);
        current_floor = 2'd3; door = 1'b1; cycles(4);
        check("out_of_range_floor", 32'(req_floor), 32'b100);
        door = 1'b0; cycles(3);

        // Dwell with door held: pulses after door-high cycles 8 and 16 only.
        current_floor = 2'd1; door = 1'b1;
        mask = '0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (timer_expired) mask[i] = 1'b1;
        end
        check("dwell_pulse_mask", mask, 32'h0001_0100);

        // Door dropped after 5 cycles: no pulse, and reopening restarts.
        door = 1'b0; cycles(2);
        door = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (timer_expired) pulses++;
        end
        door = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (timer_expired) pulses++;
        end
        check("dwell_abort", 32'(pulses), 32'd0);

`ifdef DOOR_HOLD_EN
        // Hold over cycles 6-10 suppresses the pulse at 8; first pulse at 18.
        door = 1'b1;
        first_seen = 0;
        for (int i = 1; i <= 25; i++) begin
            hold_v = (i >= 6 && i <= 10);
            cycle();
            if (first_seen == 0 && timer_expired) first_seen = i;
        end
        hold_v = 1'b0;
        check("hold_first_pulse", 32'(first_seen), 32'd18);
        door = 1'b0; hold_v = 1'b1; cycles(3); hold_v = 1'b0;
`endif

        // Random traffic: sticky buttons, occasional door toggles.
        for (int i = 0; i < 600; i++) begin
            for (int f = 0; f < NF; f++)
                if ($urandom_range(5) == 0) btn[f] = ~btn[f];
            if ($urandom_range(9) == 0) door = ~door;
            if ($urandom_range(7) == 0) current_floor = FW'($urandom_range(3));
`ifdef DOOR_HOLD_EN
            hold_v = ($urandom_range(15) == 0);
`endif
            cycle();
        end

        // Reset mid-operation drops requests and any dwell in progress.
        btn = 3'b011; door = 1'b1; current_floor = 2'd2; hold_v = 1'b0;
        cycles(7);
        reset = 1'b1;
        #1;
        check("midreset_req_floor", 32'(req_floor), 32'd0);
        check("midreset_req_pending", 32'(req_pending), 32'd0);
        check("midreset_timer_expired", 32'(timer_expired), 32'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        cycles(12);
        for (int i = 0; i < 150; i++) begin
            for (int f = 0; f < NF; f++)
                if ($urandom_range(4) == 0) btn[f] = ~btn[f];
            if ($urandom_range(8) == 0) door = ~door;
            if ($urandom_range(5) == 0) current_floor = FW'($urandom_range(3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
